// File: rtl/game_pkg.sv
// Shared types and constants for the SUM game round sequencer.
// State encoding is fixed so it can be probed and compared against the game docs.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [3:0] BCD_ZERO       = 4'd0;
  localparam int         MAX_ROUNDS_DEF = 5;

  typedef struct packed {
    logic tmr_rst;
    logic round_active;
    logic round_win;
    logic round_lose;
    logic game_over;
  } ctrl_flags_t;

  // Moore output decode; registered against the next state so outputs line up with it.
  function automatic ctrl_flags_t decode_flags(input state_t s);
    ctrl_flags_t f;
    f              = '0;
    f.tmr_rst      = (s == ST_IDLE) || (s == ST_ARM) || (s == ST_DONE);
    f.round_active = (s == ST_RUN);
    f.round_win    = (s == ST_WIN);
    f.round_lose   = (s == ST_LOSE);
    f.game_over    = (s == ST_DONE);
    return f;
  endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Handshake/bus signals between the game logic, the BCD timer and the round sequencer.
// master = game/timer side, slave = round_timer_ctrl.
interface round_timer_ctrl_if #(
  parameter int ROUND_W = 4,
  parameter int SCORE_W = 4
);
  logic               start;
  logic               pulse;
  logic               guess_valid;
  logic               guess_correct;
  logic [3:0]         tmr_tens;
  logic [3:0]         tmr_ones;
  logic               tmr_rst;
  logic               tmr_pulse;
  logic               round_active;
  logic               round_win;
  logic               round_lose;
  logic               game_over;
  logic [ROUND_W-1:0] round_num;
  logic [SCORE_W-1:0] score;

  modport master (
    output start, pulse, guess_valid, guess_correct, tmr_tens, tmr_ones,
    input  tmr_rst, tmr_pulse, round_active, round_win, round_lose, game_over,
           round_num, score
  );

  modport slave (
    input  start, pulse, guess_valid, guess_correct, tmr_tens, tmr_ones,
    output tmr_rst, tmr_pulse, round_active, round_win, round_lose, game_over,
           round_num, score
  );
endinterface

// File: rtl/round_timer_ctrl.sv
// Round sequencer: reloads/gates the BCD countdown timer, ends rounds on a correct
// guess or expiry, counts rounds and score, and flags game over after MAX_ROUNDS.
module round_timer_ctrl
  import game_pkg::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter int ROUND_W    = 4,
  parameter int SCORE_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  round_timer_ctrl_if.slave bus
);

  state_t             state;
  state_t             state_nxt;
  ctrl_flags_t        flags_q;
  logic [ROUND_W-1:0] round_q;
  logic [SCORE_W-1:0] score_q;

  logic correct;
  logic expired;
  logic last_round;

  assign correct    = bus.guess_valid & bus.guess_correct;
  // Out-of-range digits are nonzero, so they never count as expiry.
  assign expired    = (bus.tmr_tens == BCD_ZERO) && (bus.tmr_ones == BCD_ZERO);
  assign last_round = (round_q == ROUND_W'(MAX_ROUNDS));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_ARM;
      ST_ARM:    state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_RUN;
      ST_RUN: begin
        // A correct guess wins a tie with expiry.
        if (correct)      state_nxt = ST_WIN;
        else if (expired) state_nxt = ST_LOSE;
      end
      ST_WIN, ST_LOSE: state_nxt = last_round ? ST_DONE : ST_ARM;
      ST_DONE:   if (bus.start) state_nxt = ST_ARM;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      flags_q <= decode_flags(ST_IDLE);
      round_q <= '0;
      score_q <= '0;
    end else begin
      state   <= state_nxt;
      flags_q <= decode_flags(state_nxt);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            round_q <= ROUND_W'(1);
            score_q <= '0;
          end
        end
        ST_RUN: begin
          if (correct && (score_q != {SCORE_W{1'b1}}))
            score_q <= score_q + SCORE_W'(1);
        end
        ST_WIN, ST_LOSE: begin
          if (!last_round)
            round_q <= round_q + ROUND_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.tmr_rst      = flags_q.tmr_rst;
  assign bus.round_active = flags_q.round_active;
  assign bus.round_win    = flags_q.round_win;
  assign bus.round_lose   = flags_q.round_lose;
  assign bus.game_over    = flags_q.game_over;
  assign bus.round_num    = round_q;
  assign bus.score        = score_q;
  assign bus.tmr_pulse    = bus.pulse & (state == ST_RUN);

endmodule

// File: doc/round_timer_ctrl.md
Name: round_timer_ctrl

Overview:
Round sequencer for the Scrambled Number SUM game. It owns the countdown timer's reload (rst) and tick (pulse) inputs, starts each round, and ends the round on a correct guess or on timer expiry. It tracks the round count and the score, and flags game over after MAX_ROUNDS rounds. It sits between the top-level game FSM/input logic and the two-digit BCD timer.

Parameters:
MAX_ROUNDS, 5, rounds per game (1..15)
ROUND_W, 4, width of round counter
SCORE_W, 4, width of score counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  level; begins a game from IDLE or DONE
pulse  input  1  1-cycle tick from the prescaler (1 Hz)
guess_valid  input  1  1-cycle strobe; a guess was submitted
guess_correct  input  1  qualifies guess_valid; the guess matched the sum
tmr_tens  input  4  timer tens digit (timerOut2), BCD
tmr_ones  input  4  timer ones digit (timerOut1), BCD
tmr_rst  output  1  reload request to timer rst
tmr_pulse  output  1  gated tick to timer pulse
round_active  output  1  high while the round is running
round_win  output  1  1-cycle strobe; round won
round_lose  output  1  1-cycle strobe; round timed out
game_over  output  1  high in DONE
round_num  output  ROUND_W  current round, 1-based; 0 in IDLE
score  output  SCORE_W  rounds won this game

Behaviour:
- Reset (async, rst=1): state IDLE. tmr_rst=1; round_num=0; score=0; all other outputs 0.
- Outputs are Moore-decoded from state, except tmr_pulse = pulse AND (state==RUN), which is combinational.
- States: IDLE, ARM, SETTLE, RUN, WIN, LOSE, DONE.
- IDLE: tmr_rst=1. When start=1 → ARM. round_num←1; score←0.
- ARM: tmr_rst=1 for exactly 1 cycle, which reloads the timer → SETTLE.
- SETTLE: tmr_rst=0. One cycle, so the reloaded digits are valid → RUN. Expiry is never checked in ARM or SETTLE.
- RUN: round_active=1; ticks are forwarded through tmr_pulse.
  - Priority 1: guess_valid & guess_correct → WIN. score←score+1, saturating at all-ones.
  - Priority 2: tmr_tens==0 && tmr_ones==0 → LOSE.
  - guess_valid & !guess_correct: no state change.
  - A correct guess in the same cycle as zero digits → WIN (the guess wins the tie).
  - start is ignored in RUN.
- WIN / LOSE: round_win or round_lose high for exactly 1 cycle.
  - If round_num==MAX_ROUNDS → DONE.
  - Else round_num←round_num+1 and → ARM.
- DONE: game_over=1; tmr_rst=1; score and round_num hold. When start=1 → ARM, with round_num←1 and score←0.
- Latency:
  - start sampled → first RUN cycle: 3 clocks (IDLE→ARM→SETTLE→RUN).
  - correct guess → round_win: 1 clock.
  - WIN/LOSE → next RUN: 3 clocks.
- round_win, round_lose and game_over are never asserted together. round_win and round_lose never last more than 1 cycle.
- rst asserted mid-round: immediate return to the reset values, with no strobe emitted.
- guess_* and pulse are don't-care outside RUN. tmr_pulse is 0 outside RUN.
- Out-of-range BCD digits (>9) are nonzero and therefore not expiry.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants: ST_IDLE=0, ST_ARM=1, ST_SETTLE=2, ST_RUN=3, ST_WIN=4, ST_LOSE=5, ST_DONE=6 (3 bits)
  - BCD_ZERO=4'd0
  - the MAX_ROUNDS default
- No sub-module. The single FSM plus counters is natural. A testbench-only timer model may be instantiated for integration runs.

Test Plan:
- Reset mid-RUN (rst high at round_num=2, score=1) → same cycle: tmr_rst=1, round_num=0, score=0, round_active=0, no strobe.
- start in IDLE → ARM (tmr_rst=1, 1 cycle) → SETTLE → RUN 3 clocks after start. round_num=1. Pulses on pulse appear on tmr_pulse only while in RUN.
- In RUN, drive digits 0/0 → round_lose 1 cycle later, score stays 0, round_num→2, tmr_rst pulses once.
- In RUN, guess_valid=1 with guess_correct=0 → stays in RUN. Then guess_valid=1 with guess_correct=1 → round_win for 1 cycle, score=1.
- Tie: correct guess in the same cycle as digits 0/0 → round_win=1, round_lose=0, score increments.
- MAX_ROUNDS=5: win 3, lose 2 → after the 5th strobe, game_over=1, score=3, round_num=5. start → round_num=1, score=0, game_over=0.
